// File: rtl/mem_access_unit.sv
// Load/store access unit in front of the word-wide data memory.
// Handles byte/half/word accesses; sub-word stores are done as read-modify-write.
module mem_access_unit #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid & req_ready;
  // req_ready is high only in IDLE, req_* are ignored after the transfer, and the
  // response is a single-cycle resp_valid pulse with no backpressure.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        live_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        err_q;

  logic        accept;
  logic        illegal;
  logic        word_store;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept     = req_valid & req_ready;
  assign illegal    = (req_size == 2'b11)
                    | ((req_size == 2'b01) & req_addr[0])
                    | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
  assign word_store = req_we & (req_size == 2'b10);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal)         state_d = RESP;
          else if (word_store) state_d = WR;
          else                 state_d = RD;
        end
      end
      RD:      state_d = CAP;
      CAP:     state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = live_q & (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_err   = (state_q == RESP) & err_q;
    mem_we     = (state_q == WR);
    dbg_state  = state_q;
  end

  // Little-endian lane selection on the word returned in CAP.
  always_comb begin
    byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
      2'b01:   load_ext = {{16{half_sel[15] & ~uns_q}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (size_q == 2'b00)
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else if (lane_q[1])
      merged[31:16] = wdata_q;
    else
      merged[15:0] = wdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        lane_q  <= req_addr[1:0];
        wdata_q <= req_wdata[15:0];
        err_q   <= illegal;
        // Erroring requests never touch the memory port, so it keeps its last values.
        if (!illegal) begin
          mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
          if (word_store) mem_wdata <= req_wdata;
        end
      end
      if (state_q == CAP) begin
        if (we_q) mem_wdata  <= merged;
        else      resp_rdata <= load_ext;
      end
      if ((state_q == WR) || ((state_q == IDLE) && accept && illegal))
        resp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: behavioural data memory, reference
// memory model and an expected-response queue checked on every resp_valid.
module tb_mem_access_unit;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [2:0]        dbg_state;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  // ---------------- behavioural data memory ----------------
  logic        clr;
  logic [31:0] mem [8];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else begin
      if (mem_we) mem[mem_addr[4:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[4:2]];
    end
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic [31:0] ref_mem [8];
  int          we_cnt = 0;
  logic [31:0] last_waddr;
  logic [31:0] last_wdata;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && mem_we) begin
      we_cnt++;
      last_waddr = 32'(mem_addr);
      last_wdata = mem_wdata;
      check_eq("waddr_align", 32'(mem_addr[1:0]), 32'h0);
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_resp", 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check_eq("resp_err", 32'(resp_err), 32'(e[32]));
        check_eq("resp_rdata", resp_rdata, e[31:0]);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic ref_illegal(input logic [1:0] size, input logic [4:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns, input logic [4:0] addr);
    logic [31:0] v;
    v = ref_mem[addr[4:2]] >> (32'(addr[1:0]) * 8);
    if (size == 2'd0) return uns ? {24'h0, v[7:0]} : 32'($signed(v[7:0]));
    if (size == 2'd1) return uns ? {16'h0, v[15:0]} : 32'($signed(v[15:0]));
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [4:0] addr, input logic [31:0] wdata,
                      input logic exp_err, input logic [31:0] exp_rdata,
                      input int exp_lat, input int exp_wes);
    int lat;
    int w0;
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", 32'(req_ready), 32'h1);
    w0 = we_cnt;
    exp_q.push_back({exp_err, exp_rdata});
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_we = $urandom_range(0, 1); req_addr = 5'($urandom); req_wdata = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 12);
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("we_cycles", 32'(we_cnt - w0), 32'(exp_wes));
  endtask

  task automatic do_load(input logic [1:0] size, input logic uns, input logic [4:0] addr);
    if (ref_illegal(size, addr)) send(1'b0, size, uns, addr, 32'h0, 1'b1, 32'h0, 1, 0);
    else                         send(1'b0, size, uns, addr, 32'h0, 1'b0, ref_load(size, uns, addr), 3, 0);
  endtask

  task automatic do_store(input logic [1:0] size, input logic [4:0] addr, input logic [31:0] wdata);
    logic [31:0] mask;
    int sh;
    if (ref_illegal(size, addr)) begin
      send(1'b1, size, 1'b0, addr, wdata, 1'b1, 32'h0, 1, 0);
    end else if (size == 2'd2) begin
      send(1'b1, size, 1'b0, addr, wdata, 1'b0, 32'h0, 2, 1);
      ref_mem[addr[4:2]] = wdata;
    end else begin
      send(1'b1, size, 1'b0, addr, wdata, 1'b0, 32'h0, 4, 1);
      sh   = 32'(addr[1:0]) * 8;
      mask = ((size == 2'd0) ? 32'hff : 32'hffff) << sh;
      ref_mem[addr[4:2]] = (ref_mem[addr[4:2]] & ~mask) | ((wdata << sh) & mask);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b0; clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 8; i++) ref_mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
    check_eq("rst_resp_err", 32'(resp_err), 32'h0);
    check_eq("rst_rdata", resp_rdata, 32'h0);
    check_eq("rst_mem_we", 32'(mem_we), 32'h0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    clr = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", 32'(req_ready), 32'h1);

    // word round-trip
    do_store(2'd2, 5'd4, 32'hAABBCCD0);
    check_eq("ws_addr", last_waddr, 32'd4);
    check_eq("ws_data", last_wdata, 32'hAABBCCD0);
    send(1'b0, 2'd2, 1'b0, 5'd4, 32'h0, 1'b0, 32'hAABBCCD0, 3, 0);

    // byte store merge
    do_store(2'd0, 5'd5, 32'h123456EE);
    check_eq("bs_addr", last_waddr, 32'd4);
    check_eq("bs_merge", last_wdata, 32'hAABBEED0);
    send(1'b0, 2'd2, 1'b0, 5'd4, 32'h0, 1'b0, 32'hAABBEED0, 3, 0);

    // load extension
    send(1'b0, 2'd0, 1'b0, 5'd7, 32'h0, 1'b0, 32'hFFFFFFAA, 3, 0);
    send(1'b0, 2'd0, 1'b1, 5'd7, 32'h0, 1'b0, 32'h000000AA, 3, 0);
    send(1'b0, 2'd1, 1'b0, 5'd6, 32'h0, 1'b0, 32'hFFFFAABB, 3, 0);
    send(1'b0, 2'd1, 1'b1, 5'd4, 32'h0, 1'b0, 32'h0000EED0, 3, 0);

    // illegal requests
    send(1'b0, 2'd1, 1'b0, 5'd5, 32'h0, 1'b1, 32'h0, 1, 0);
    send(1'b1, 2'd2, 1'b0, 5'd6, 32'h11223344, 1'b1, 32'h0, 1, 0);
    send(1'b0, 2'd3, 1'b0, 5'd4, 32'h0, 1'b1, 32'h0, 1, 0);
    send(1'b1, 2'd3, 1'b0, 5'd4, 32'h55667788, 1'b1, 32'h0, 1, 0);
    send(1'b0, 2'd2, 1'b0, 5'd4, 32'h0, 1'b0, 32'hAABBEED0, 3, 0);

    // reset during the WR cycle of a half store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 5'd4; req_wdata = 32'h00009999;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("abort_we_high", 32'(mem_we), 32'h1);
    #1 rst = 1'b0;
    #1;
    check_eq("abort_we_low", 32'(mem_we), 32'h0);
    check_eq("abort_resp_valid", 32'(resp_valid), 32'h0);
    check_eq("abort_resp_err", 32'(resp_err), 32'h0);
    check_eq("abort_rdata", resp_rdata, 32'h0);
    check_eq("abort_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_ready_after", 32'(req_ready), 32'h1);
    send(1'b0, 2'd2, 1'b0, 5'd4, 32'h0, 1'b0, 32'hAABBEED0, 3, 0);

    // back-to-back loads with req_valid held
    @(negedge clk);
    exp_q.push_back({1'b0, ref_load(2'd2, 1'b0, 5'd4)});
    exp_q.push_back({1'b0, ref_load(2'd0, 1'b1, 5'd7)});
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 5'd4;
    @(posedge clk);
    #1 req_size = 2'd0; req_unsigned = 1'b1; req_addr = 5'd7;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1 || c == 2 || c == 3 || c == 5 || c == 6 || c == 7)
        check_eq("b2b_busy", 32'(req_ready), 32'h0);
      if (c == 3 || c == 7) check_eq("b2b_resp", 32'(resp_valid), 32'h1);
      if (c == 4) begin
        check_eq("b2b_pulse", 32'(resp_valid), 32'h0);
        check_eq("b2b_idle", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end

    // random legal/illegal mix against the reference memory
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  sz;
      logic [4:0]  ad;
      sz = 2'($urandom_range(0, 3));
      ad = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) do_store(sz, ad, $urandom);
      else                           do_load(sz, 1'($urandom_range(0, 1)), ad);
    end
    for (int w = 0; w < 8; w++) do_load(2'd2, 1'b0, 5'(w * 4));

    repeat (4) @(negedge clk);
    check_eq("drain", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
